// File: rtl/mobile_dial_ctrl.sv
// -----------------------------------------------------------------------------
// mobile_dial_ctrl
//
// Purpose:
//   Holds a small store of 4-bit dial digits and, on request, plays them out
//   one at a time over a valid/ready handshake. Consecutive digits are
//   separated by a programmable number of idle cycles.
//
// Parameters:
//   NUM_DIGITS  digits per dial sequence (1..16)
//   GAP_CYCLES  idle cycles between an accepted digit and the next offer (0..255)
//
// Optional feature (compile-time macro):
//   MOBILE_DIAL_BCD_CHECK_EN  when defined, a stored value above 9 is refused
//                             as it comes up for sending: err pulses and the
//                             sequence ends without done. When undefined,
//                             every value is sent unchanged and err stays 0.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   load_en     digit store write strobe (honoured only while idle)
//   load_idx    digit store write address
//   load_digit  digit value to store
//   start       single-cycle request to begin a sequence
//   abort       ends an active sequence without done
//   dig_ready   downstream sink accepts the offered digit
//   dig_valid   dig_out/dig_idx carry a valid digit
//   dig_out     current digit value (0 when not valid)
//   dig_idx     position of the current digit (0 when not valid)
//   busy        high in any state other than IDLE
//   done        one-cycle pulse when the last digit has been accepted
//   err         one-cycle pulse on a refused digit value
// -----------------------------------------------------------------------------
module mobile_dial_ctrl #(
  parameter int NUM_DIGITS = 10,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_en,
  input  logic [3:0] load_idx,
  input  logic [3:0] load_digit,
  input  logic       start,
  input  logic       abort,
  input  logic       dig_ready,
  output logic       dig_valid,
  output logic [3:0] dig_out,
  output logic [3:0] dig_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_IDX  = 4'(NUM_DIGITS - 1);
  localparam logic [4:0] NUM_DIG_W = 5'(NUM_DIGITS);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_idx;
  logic [3:0] w_idx_nxt;
  logic [7:0] r_gap_cnt;
  logic [7:0] w_gap_cnt_nxt;

  // The store is always 16 deep so a 4-bit index never runs off the end;
  // entries at or above NUM_DIGITS are never written and stay at zero.
  logic [3:0] r_store [16];

  logic [3:0] w_cur_digit;
  logic       w_bad_digit;
  logic       w_accept;
  logic       w_load_ok;

  assign w_cur_digit = r_store[r_idx];
  assign w_load_ok   = load_en && (r_state == IDLE) && ({1'b0, load_idx} < NUM_DIG_W);

`ifdef MOBILE_DIAL_BCD_CHECK_EN
  // Checked combinationally while sitting in SEND, so the refused digit is
  // never presented as valid and the FSM leaves SEND on the following edge.
  assign w_bad_digit = (r_state == SEND) && (w_cur_digit > 4'd9);
`else
  assign w_bad_digit = 1'b0;
`endif

  // Outputs are decoded from registered state so an asynchronous reset
  // clears them immediately, without waiting for a clock edge.
  always_comb begin
    dig_valid = (r_state == SEND) && !w_bad_digit;
    dig_out   = dig_valid ? w_cur_digit : 4'd0;
    dig_idx   = dig_valid ? r_idx : 4'd0;
    busy      = (r_state != IDLE);
    // An abort landing on the completion cycle cancels the done pulse.
    done      = (r_state == DONE) && !abort;
    err       = w_bad_digit;
  end

  assign w_accept = dig_valid && dig_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_gap_cnt_nxt = r_gap_cnt;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt   = SEND;
          w_idx_nxt     = 4'd0;
          w_gap_cnt_nxt = 8'd0;
        end
      end
      SEND: begin
        // Abort wins over a same-cycle accept: the beat still transfers on
        // the handshake, but the sequence ends here.
        if (abort || w_bad_digit) begin
          w_state_nxt   = IDLE;
          w_idx_nxt     = 4'd0;
          w_gap_cnt_nxt = 8'd0;
        end else if (w_accept) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = DONE;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
            if (GAP_CYCLES == 0) begin
              w_state_nxt = SEND;
            end else begin
              w_state_nxt   = GAP;
              w_gap_cnt_nxt = GAP_LOAD;
            end
          end
        end
      end
      GAP: begin
        if (abort) begin
          w_state_nxt   = IDLE;
          w_idx_nxt     = 4'd0;
          w_gap_cnt_nxt = 8'd0;
        end else if (r_gap_cnt <= 8'd1) begin
          // Counter is loaded with GAP_CYCLES, so leaving on the count of 1
          // gives exactly GAP_CYCLES idle cycles.
          w_state_nxt   = SEND;
          w_gap_cnt_nxt = 8'd0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 8'd1;
        end
      end
      DONE: begin
        w_state_nxt   = IDLE;
        w_idx_nxt     = 4'd0;
        w_gap_cnt_nxt = 8'd0;
      end
      default: begin
        w_state_nxt   = IDLE;
        w_idx_nxt     = 4'd0;
        w_gap_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= 4'd0;
      r_gap_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

  // A load in the same cycle as start lands on this edge, ahead of the
  // first SEND cycle, so the sequence sees the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_store[i] <= 4'd0;
      end
    end else if (w_load_ok) begin
      r_store[load_idx] <= load_digit;
    end
  end

endmodule

// File: tb/tb_mobile_dial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mobile_dial_ctrl
//
// Self-checking bench for mobile_dial_ctrl (NUM_DIGITS=10, GAP_CYCLES=4).
// Expected beats (index, value, acceptance cycle) are queued when a sequence
// is started; a negedge monitor pops and compares each accepted beat. The
// scenario tasks check timing of done/busy/err and special behaviour inline.
// -----------------------------------------------------------------------------
module tb_mobile_dial_ctrl;

  localparam int ND   = 10;
  localparam int GAP  = 4;
  localparam int STEP = GAP + 1;

  logic       clk;
  logic       rst;
  logic       load_en;
  logic [3:0] load_idx;
  logic [3:0] load_digit;
  logic       start;
  logic       abort;
  logic       dig_ready;
  logic       dig_valid;
  logic [3:0] dig_out;
  logic [3:0] dig_idx;
  logic       busy;
  logic       done;
  logic       err;

  mobile_dial_ctrl #(
    .NUM_DIGITS(ND),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .load_idx   (load_idx),
    .load_digit (load_digit),
    .start      (start),
    .abort      (abort),
    .dig_ready  (dig_ready),
    .dig_valid  (dig_valid),
    .dig_out    (dig_out),
    .dig_idx    (dig_idx),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] idx;
    logic [3:0] dig;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int checks    = 0;
  int passes    = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  int last_done = -1;
  int last_err  = -1;

  logic [3:0] m_store [16];

  // Scoreboard monitor: every accepted beat must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (dig_valid && dig_ready) begin
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_beat: got idx=%0d val=%0d at cycle %0d, none expected",
                   dig_idx, dig_out, cyc);
        end else begin
          e = sb.pop_front();
          if (dig_idx !== e.idx || dig_out !== e.dig || cyc !== e.cyc)
            $display("FAIL beat: got idx=%0d val=%0d cyc=%0d, want idx=%0d val=%0d cyc=%0d",
                     dig_idx, dig_out, cyc, e.idx, e.dig, e.cyc);
          else
            passes++;
        end
      end
      if (!dig_valid && (dig_out !== 4'd0 || dig_idx !== 4'd0)) begin
        checks++;
        $display("FAIL idle_outputs: got val=%0d idx=%0d at cycle %0d, want 0/0",
                 dig_out, dig_idx, cyc);
      end
      if (done) begin
        done_cnt++;
        last_done = cyc;
      end
      if (err) begin
        err_cnt++;
        last_err = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic load(input int idx, input int val);
    @(posedge clk); #1;
    load_en    = 1'b1;
    load_idx   = 4'(idx);
    load_digit = 4'(val);
    @(posedge clk); #1;
    load_en    = 1'b0;
    if (idx < ND) m_store[idx] = 4'(val);
  endtask

  // Pulses start and queues the expected beats idx 0..last_idx; beats at or
  // after stall_idx are accepted stall_len cycles later.
  task automatic start_seq(output int t, input int stall_idx, input int stall_len,
                           input int last_idx);
    exp_t x;
    @(posedge clk); #1;
    start = 1'b1;
    t = cyc;
    for (int i = 0; i <= last_idx; i++) begin
      x.idx = 4'(i);
      x.dig = m_store[i];
      x.cyc = t + 1 + STEP * i + ((i >= stall_idx) ? stall_len : 0);
      sb.push_back(x);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(output int t_idle, input int budget);
    t_idle = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) begin
        t_idle = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (dig_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dig_valid); else passes++;
    checks++; if (dig_out !== 4'd0) $display("FAIL reset_out: got %0d want 0", dig_out); else passes++;
    checks++; if (dig_idx !== 4'd0) $display("FAIL reset_idx: got %0d want 0", dig_idx); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_dial;
    int t, t_idle, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_seq(t, 99, 0, ND - 1);
    wait_idle(t_idle, 100);
    checks++; if (t_idle !== t + STEP * (ND - 1) + 3)
      $display("FAIL dial_idle_cycle: got %0d want %0d", t_idle, t + STEP * (ND - 1) + 3); else passes++;
    checks++; if (done_cnt - d0 !== 1)
      $display("FAIL dial_done_count: got %0d want 1", done_cnt - d0); else passes++;
    checks++; if (last_done !== t + STEP * (ND - 1) + 2)
      $display("FAIL dial_done_cycle: got %0d want %0d", last_done, t + STEP * (ND - 1) + 2); else passes++;
    checks++; if (err_cnt - e0 !== 0)
      $display("FAIL dial_err_count: got %0d want 0", err_cnt - e0); else passes++;
    checks++; if (sb.size() !== 0)
      $display("FAIL dial_missing_beats: got %0d left want 0", sb.size()); else passes++;
    sb.delete();
  endtask

  task automatic test_backpressure;
    int t, t_idle, d0, ts;
    d0 = done_cnt;
    t_idle = -1;
    start_seq(t, 2, 3, ND - 1);
    ts = t + 1 + 2 * STEP;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (cyc == ts) dig_ready = 1'b0;
      if (cyc == ts + 3) dig_ready = 1'b1;
      @(negedge clk);
      if (cyc >= ts && cyc <= ts + 3) begin
        checks++;
        if (dig_valid !== 1'b1 || dig_out !== 4'd7 || dig_idx !== 4'd2)
          $display("FAIL stall_hold: got v=%b val=%0d idx=%0d at cycle %0d want v=1 val=7 idx=2",
                   dig_valid, dig_out, dig_idx, cyc);
        else passes++;
      end
      if (!busy) begin
        t_idle = cyc;
        break;
      end
    end
    dig_ready = 1'b1;
    checks++; if (t_idle !== t + STEP * (ND - 1) + 6)
      $display("FAIL stall_idle_cycle: got %0d want %0d", t_idle, t + STEP * (ND - 1) + 6); else passes++;
    checks++; if (done_cnt - d0 !== 1)
      $display("FAIL stall_done_count: got %0d want 1", done_cnt - d0); else passes++;
    checks++; if (last_done !== t + STEP * (ND - 1) + 5)
      $display("FAIL stall_done_cycle: got %0d want %0d", last_done, t + STEP * (ND - 1) + 5); else passes++;
    checks++; if (sb.size() !== 0)
      $display("FAIL stall_missing_beats: got %0d left want 0", sb.size()); else passes++;
    sb.delete();
  endtask

  task automatic test_abort;
    int t, d0, ta;
    d0 = done_cnt;
    start_seq(t, 99, 0, 4);
    ta = t + 1 + 4 * STEP + 2;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      abort = (cyc == ta);
      @(negedge clk);
      if (cyc == ta + 1) begin
        checks++;
        if (busy !== 1'b0) $display("FAIL abort_to_idle: got busy=%b at cycle %0d want 0", busy, cyc);
        else passes++;
      end
    end
    abort = 1'b0;
    checks++; if (done_cnt - d0 !== 0)
      $display("FAIL abort_done_count: got %0d want 0", done_cnt - d0); else passes++;
    checks++; if (sb.size() !== 0)
      $display("FAIL abort_missing_beats: got %0d left want 0", sb.size()); else passes++;
    sb.delete();
  endtask

  task automatic test_ignored_loads;
    int t, t_idle, d0;
    d0 = done_cnt;
    t_idle = -1;
    load(12, 5);
    start_seq(t, 99, 0, ND - 1);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      load_en    = (cyc >= t + 2 && cyc <= t + 6);
      load_idx   = 4'd0;
      load_digit = 4'd3;
      start      = (cyc == t + 10);
      @(negedge clk);
      if (!busy) begin
        t_idle = cyc;
        break;
      end
    end
    load_en = 1'b0;
    start   = 1'b0;
    checks++; if (t_idle !== t + STEP * (ND - 1) + 3)
      $display("FAIL busy_load_idle_cycle: got %0d want %0d", t_idle, t + STEP * (ND - 1) + 3); else passes++;
    checks++; if (done_cnt - d0 !== 1)
      $display("FAIL busy_load_done_count: got %0d want 1", done_cnt - d0); else passes++;
    checks++; if (sb.size() !== 0)
      $display("FAIL busy_load_missing_beats: got %0d left want 0", sb.size()); else passes++;
    sb.delete();
  endtask

  task automatic test_digit_over_nine;
    int t, t_idle, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    load(3, 12);
`ifdef MOBILE_DIAL_BCD_CHECK_EN
    start_seq(t, 99, 0, 2);
    wait_idle(t_idle, 100);
    checks++; if (err_cnt - e0 !== 1)
      $display("FAIL bcd_err_count: got %0d want 1", err_cnt - e0); else passes++;
    checks++; if (last_err !== t + 1 + 3 * STEP)
      $display("FAIL bcd_err_cycle: got %0d want %0d", last_err, t + 1 + 3 * STEP); else passes++;
    checks++; if (t_idle !== t + 2 + 3 * STEP)
      $display("FAIL bcd_idle_cycle: got %0d want %0d", t_idle, t + 2 + 3 * STEP); else passes++;
    checks++; if (done_cnt - d0 !== 0)
      $display("FAIL bcd_done_count: got %0d want 0", done_cnt - d0); else passes++;
`else
    start_seq(t, 99, 0, ND - 1);
    wait_idle(t_idle, 100);
    checks++; if (err_cnt - e0 !== 0)
      $display("FAIL raw_err_count: got %0d want 0", err_cnt - e0); else passes++;
    checks++; if (t_idle !== t + STEP * (ND - 1) + 3)
      $display("FAIL raw_idle_cycle: got %0d want %0d", t_idle, t + STEP * (ND - 1) + 3); else passes++;
    checks++; if (done_cnt - d0 !== 1)
      $display("FAIL raw_done_count: got %0d want 1", done_cnt - d0); else passes++;
`endif
    checks++; if (sb.size() !== 0)
      $display("FAIL over_nine_missing_beats: got %0d left want 0", sb.size()); else passes++;
    sb.delete();
    load(3, 6);
  endtask

  task automatic test_async_reset;
    int t, t_idle, d0;
    start_seq(t, 99, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL async_busy: got %b want 0", busy); else passes++;
    checks++; if (dig_valid !== 1'b0) $display("FAIL async_valid: got %b want 0", dig_valid); else passes++;
    checks++; if (dig_out !== 4'd0 || dig_idx !== 4'd0)
      $display("FAIL async_data: got val=%0d idx=%0d want 0/0", dig_out, dig_idx); else passes++;
    checks++; if (done !== 1'b0 || err !== 1'b0)
      $display("FAIL async_pulses: got done=%b err=%b want 0/0", done, err); else passes++;
    checks++; if (sb.size() !== 0)
      $display("FAIL async_missing_beats: got %0d left want 0", sb.size()); else passes++;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m_store[i] = 4'd0;
    d0 = done_cnt;
    start_seq(t, 99, 0, ND - 1);
    wait_idle(t_idle, 100);
    checks++; if (t_idle !== t + STEP * (ND - 1) + 3)
      $display("FAIL post_reset_idle_cycle: got %0d want %0d", t_idle, t + STEP * (ND - 1) + 3); else passes++;
    checks++; if (done_cnt - d0 !== 1)
      $display("FAIL post_reset_done_count: got %0d want 1", done_cnt - d0); else passes++;
    checks++; if (sb.size() !== 0)
      $display("FAIL post_reset_missing_beats: got %0d left want 0", sb.size()); else passes++;
    sb.delete();
  endtask

  initial begin
    rst        = 1'b1;
    load_en    = 1'b0;
    load_idx   = 4'd0;
    load_digit = 4'd0;
    start      = 1'b0;
    abort      = 1'b0;
    dig_ready  = 1'b1;
    for (int i = 0; i < 16; i++) m_store[i] = 4'd0;

    test_reset();
    for (int i = 0; i < ND; i++) load(i, 9 - i);
    test_dial();
    test_backpressure();
    test_abort();
    test_dial();
    test_ignored_loads();
    test_dial();
    test_digit_over_nine();
    test_async_reset();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
